hvsync_pattern_ctrl: RTL and testbench
======================================

HVSYNC_PATTERN_CTRL -- requirements
Module: hvsync_pattern_ctrl

Interface
REQ-001 SHALL provide parameters H_DISPLAY=640, H_FRONT=16, H_SYNC=96, H_BACK=48, V_DISPLAY=480, V_BOTTOM=10, V_SYNC=2 and V_TOP=33, giving H_TOTAL=800 pixels and V_TOTAL=525 lines.
REQ-002 SHALL have the following ports:
- clk  input  1  system clock, 2x pixel rate.
- reset  input  1  reset, asynchronous, active-high.
- keys  input  4  raw asynchronous buttons, active-high.
- pix_en  output  1  pixel-rate enable, high every second clk.
- hsync  output  1  horizontal sync, active-low.
- vsync  output  1  vertical sync, active-low.
- display_on  output  1  visible-area flag.
- hpos  output  10  current pixel column.
- vpos  output  10  current line.
- frame_start  output  1  one-clk frame strobe.
- mode  output  2  active test-pattern mode.
- rgb  output  3  pixel colour.
REQ-003 SHALL use clock clk for all state; reset is asynchronous, active-high; no derived or gated clocks.

Function
REQ-004 SHALL toggle pix_en every clk cycle; timing state advances only on cycles where pix_en=1.
REQ-005 SHALL advance hpos by 1 per pix_en; at H_TOTAL-1 (799) SHALL wrap hpos to 0 and advance vpos; at vpos=V_TOTAL-1 (524) with hpos wrap SHALL wrap vpos to 0.
REQ-006 SHALL drive hsync=0 iff 656<=hpos<=751 and vsync=0 iff 490<=vpos<=491 (bounds derived from parameters).
REQ-007 SHALL drive display_on=1 iff hpos<H_DISPLAY and vpos<V_DISPLAY.
REQ-008 SHALL drive hsync, vsync, display_on and rgb as registered outputs that are consistent with the hpos/vpos values presented in the same cycle.
REQ-009 SHALL pulse frame_start high for exactly one clk, namely the first clk in which hpos=0 and vpos=0 after a wrap; it SHALL NOT pulse on exit from reset.
REQ-010 SHALL synchronise keys through 2 flip-flops and detect rising edges on keys[0] (next) and keys[1] (prev).
REQ-011 SHALL hold the pending request in a 3-state FSM {IDLE, REQ_NEXT, REQ_PREV}, with these transitions:
- next edge -> REQ_NEXT.
- prev edge -> REQ_PREV.
- both edges in the same cycle -> IDLE (cancel).
- a later edge overrides an earlier one.
REQ-012 SHALL apply a pending request only in the frame_start cycle: REQ_NEXT gives mode+1 mod 4, REQ_PREV gives mode-1 mod 4, then the FSM returns to IDLE.
REQ-013 SHALL give an edge arriving in the frame_start cycle priority over the clear; that edge is retained for the next frame.
REQ-014 SHALL let any number of same-direction edges within one frame produce a single mode step.
REQ-015 SHALL produce rgb=0 whenever display_on=0; otherwise rgb depends on mode:
- mode 0: bars, rgb=hpos[8:6].
- mode 1: checker, rgb={3{hpos[5]^vpos[5]}}.
- mode 2: grid, rgb=7 when hpos[4:0]=0 or vpos[4:0]=0, else 0.
- mode 3: solid, rgb={1'b0, synchronised keys[3:2]}.

Reset
REQ-016 SHALL, while reset is high, force the following and hold them regardless of clk: pix_en=0, hpos=0, vpos=0, hsync=1, vsync=1, display_on=1, frame_start=0, mode=0, rgb=0, pending FSM=IDLE, synchronisers=0.
REQ-017 SHALL treat reset asserted mid-frame or mid-sync as an immediate return to the REQ-016 state; pending key requests are discarded.
REQ-018 SHALL raise pix_en=1 on the first clk edge after reset deasserts; hpos=1 follows at the next pix_en=1 edge.

Configuration
REQ-019 SHALL compile in, when macro HVSYNC_FRAME_CNT_EN is defined, an output port frame_cnt (8 bits, reset 0) that increments in each frame_start cycle and wraps 255->0.
REQ-020 SHALL, without HVSYNC_FRAME_CNT_EN, omit the frame_cnt port and its counter; all other behaviour is identical in both builds.

Verification
REQ-021 Free-run from reset -> pix_en period 2 clk; hpos 0..799; vpos 0..524; first frame_start exactly 2*800*525=840000 clk after the first pix_en.
REQ-022 Sync timing check -> hsync low for 96 pixels beginning at hpos=656; vsync low for lines 490..491; display_on low for hpos>=640 or vpos>=480.
REQ-023 Press keys[0] mid-frame 3 times -> mode 0->1 exactly at the next frame_start and no earlier; then press keys[1] twice in the next frame -> mode 1->0.
REQ-024 Press keys[0] and keys[1] in the same synchronised cycle -> mode unchanged at frame_start; press keys[1] from mode 0 -> mode 3 (wrap).
REQ-025 Drive a key edge in the frame_start cycle -> mode changes at the following frame_start, not the current one.
REQ-026 Assert reset at hpos=700, vpos=490 -> hsync=vsync=1 and hpos=vpos=0 immediately, mode=0; with HVSYNC_FRAME_CNT_EN defined, frame_cnt=0 and then 1 after the first frame.

Source files
------------

// File: rtl/hvsync_pattern_ctrl_if.sv
// Video timing and test-pattern outputs of hvsync_pattern_ctrl bundled as one interface.
// master = the timing generator, slave = any video sink or observer.
interface hvsync_pattern_ctrl_if;
  logic       pix_en;
  logic       hsync;
  logic       vsync;
  logic       display_on;
  logic [9:0] hpos;
  logic [9:0] vpos;
  logic       frame_start;
  logic [1:0] mode;
  logic [2:0] rgb;

  modport master (output pix_en, hsync, vsync, display_on, hpos, vpos, frame_start, mode, rgb);
  modport slave  (input  pix_en, hsync, vsync, display_on, hpos, vpos, frame_start, mode, rgb);
endinterface

// File: rtl/hvsync_pattern_ctrl.sv
// VGA-style sync generator with key-selected test patterns; clk runs at twice the pixel rate.
// Optional macro HVSYNC_FRAME_CNT_EN adds the 8-bit frame_cnt output port.
module hvsync_pattern_ctrl #(
  parameter int H_DISPLAY = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_DISPLAY = 480,
  parameter int V_BOTTOM  = 10,
  parameter int V_SYNC    = 2,
  parameter int V_TOP     = 33
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [3:0]            keys,
  hvsync_pattern_ctrl_if.master vid
`ifdef HVSYNC_FRAME_CNT_EN
  ,
  output logic [7:0]            frame_cnt
`endif
);

  localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_DISPLAY + V_BOTTOM + V_SYNC + V_TOP;

  localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS      = 10'(H_DISPLAY);
  localparam logic [9:0] V_VIS      = 10'(V_DISPLAY);
  localparam logic [9:0] HS_FIRST   = 10'(H_DISPLAY + H_FRONT);
  localparam logic [9:0] HS_LAST    = 10'(H_DISPLAY + H_FRONT + H_SYNC - 1);
  localparam logic [9:0] VS_FIRST   = 10'(V_DISPLAY + V_BOTTOM);
  localparam logic [9:0] VS_LAST    = 10'(V_DISPLAY + V_BOTTOM + V_SYNC - 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REQ_NEXT = 2'd1,
    REQ_PREV = 2'd2
  } req_state_e;

  logic       run_q, run_d;
  logic       pix_en_q, pix_en_d;
  logic [9:0] hpos_q, hpos_d;
  logic [9:0] vpos_q, vpos_d;
  logic       hsync_q, hsync_d;
  logic       vsync_q, vsync_d;
  logic       disp_q, disp_d;
  logic [2:0] rgb_q, rgb_d;
  logic       frame_start_q, frame_start_d;
  logic [1:0] mode_q, mode_d;
  logic [3:0] key_meta_q, key_meta_d;
  logic [3:0] key_sync_q, key_sync_d;
  logic [1:0] key_prev_q, key_prev_d;
  req_state_e state_q, state_d;

  logic advance;
  logic h_wrap;
  logic v_wrap;
  logic next_edge;
  logic prev_edge;

  // Timing counters, key synchronisers and registered outputs (computed from next values
  // so they line up with hpos/vpos in the same cycle).
  always_comb begin
    run_d      = 1'b1;
    pix_en_d   = ~pix_en_q;
    key_meta_d = keys;
    key_sync_d = key_meta_q;
    key_prev_d = key_sync_q[1:0];

    // The first edge after reset only raises pix_en; counting starts on the next rise.
    advance = run_q & ~pix_en_q;
    h_wrap  = (hpos_q == H_LAST);
    v_wrap  = (vpos_q == V_LAST);

    hpos_d = hpos_q;
    vpos_d = vpos_q;
    if (advance) begin
      if (h_wrap) begin
        hpos_d = '0;
        vpos_d = v_wrap ? '0 : vpos_q + 10'd1;
      end else begin
        hpos_d = hpos_q + 10'd1;
      end
    end
    frame_start_d = advance & h_wrap & v_wrap;

    hsync_d = ~((hpos_d >= HS_FIRST) && (hpos_d <= HS_LAST));
    vsync_d = ~((vpos_d >= VS_FIRST) && (vpos_d <= VS_LAST));
    disp_d  = (hpos_d < H_VIS) && (vpos_d < V_VIS);

    rgb_d = 3'd0;
    if (disp_d) begin
      case (mode_d)
        2'd0:    rgb_d = hpos_d[8:6];
        2'd1:    rgb_d = {3{hpos_d[5] ^ vpos_d[5]}};
        2'd2:    rgb_d = ((hpos_d[4:0] == 5'd0) || (vpos_d[4:0] == 5'd0)) ? 3'd7 : 3'd0;
        default: rgb_d = {1'b0, key_sync_d[3:2]};
      endcase
    end
  end

  // Pending-request FSM: a fresh edge always wins over the frame_start clear.
  always_comb begin
    next_edge = key_sync_q[0] & ~key_prev_q[0];
    prev_edge = key_sync_q[1] & ~key_prev_q[1];
    state_d   = state_q;
    mode_d    = mode_q;

    if (frame_start_q) begin
      case (state_q)
        REQ_NEXT: mode_d = mode_q + 2'd1;
        REQ_PREV: mode_d = mode_q - 2'd1;
        default:  mode_d = mode_q;
      endcase
      state_d = IDLE;
    end

    if (next_edge && prev_edge) begin
      state_d = IDLE;
    end else if (next_edge) begin
      state_d = REQ_NEXT;
    end else if (prev_edge) begin
      state_d = REQ_PREV;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      run_q         <= 1'b0;
      pix_en_q      <= 1'b0;
      hpos_q        <= '0;
      vpos_q        <= '0;
      hsync_q       <= 1'b1;
      vsync_q       <= 1'b1;
      disp_q        <= 1'b1;
      rgb_q         <= '0;
      frame_start_q <= 1'b0;
      mode_q        <= '0;
      key_meta_q    <= '0;
      key_sync_q    <= '0;
      key_prev_q    <= '0;
    end else begin
      run_q         <= run_d;
      pix_en_q      <= pix_en_d;
      hpos_q        <= hpos_d;
      vpos_q        <= vpos_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      disp_q        <= disp_d;
      rgb_q         <= rgb_d;
      frame_start_q <= frame_start_d;
      mode_q        <= mode_d;
      key_meta_q    <= key_meta_d;
      key_sync_q    <= key_sync_d;
      key_prev_q    <= key_prev_d;
    end
  end

`ifdef HVSYNC_FRAME_CNT_EN
  logic [7:0] frame_cnt_q, frame_cnt_d;

  always_comb begin
    frame_cnt_d = frame_cnt_q;
    if (frame_start_q) begin
      frame_cnt_d = frame_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      frame_cnt_q <= '0;
    end else begin
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign frame_cnt = frame_cnt_q;
`endif

  assign vid.pix_en      = pix_en_q;
  assign vid.hsync       = hsync_q;
  assign vid.vsync       = vsync_q;
  assign vid.display_on  = disp_q;
  assign vid.hpos        = hpos_q;
  assign vid.vpos        = vpos_q;
  assign vid.frame_start = frame_start_q;
  assign vid.mode        = mode_q;
  assign vid.rgb         = rgb_q;

endmodule

// File: tb/tb_hvsync_pattern_ctrl.sv
// Directed bench for hvsync_pattern_ctrl: a reduced-timing instance for whole-frame behaviour
// and a default-timing instance for the standard 640x480 line timing.
module tb_hvsync_pattern_ctrl;

  localparam int HD = 72;
  localparam int HF = 4;
  localparam int HS = 8;
  localparam int HB = 4;
  localparam int HT = HD + HF + HS + HB;   // 88
  localparam int VD = 34;
  localparam int VB = 2;
  localparam int VS = 2;
  localparam int VTP = 2;
  localparam int VT = VD + VB + VS + VTP;  // 40
  localparam int FRAME_CLK = 2 * HT * VT;  // 7040
  localparam int LIMIT = 20000;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] keys;
  int         cyc_ctr = 0;
  int         n_checks = 0;
  int         n_pass = 0;

  hvsync_pattern_ctrl_if vid();
  hvsync_pattern_ctrl_if vid_d();
`ifdef HVSYNC_FRAME_CNT_EN
  logic [7:0] fc;
  logic [7:0] fc_d;
`endif

  hvsync_pattern_ctrl #(
    .H_DISPLAY(HD), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_DISPLAY(VD), .V_BOTTOM(VB), .V_SYNC(VS), .V_TOP(VTP)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .keys  (keys),
    .vid   (vid)
`ifdef HVSYNC_FRAME_CNT_EN
    ,
    .frame_cnt (fc)
`endif
  );

  hvsync_pattern_ctrl dut_d (
    .clk   (clk),
    .reset (reset),
    .keys  (4'd0),
    .vid   (vid_d)
`ifdef HVSYNC_FRAME_CNT_EN
    ,
    .frame_cnt (fc_d)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc_ctr <= cyc_ctr + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_pos(input int h, input int v);
    int n;
    n = 0;
    while (!(int'(vid.hpos) == h && int'(vid.vpos) == v) && n < LIMIT) begin
      tick();
      n++;
    end
    check("reach_pos", (int'(vid.hpos) == h && int'(vid.vpos) == v), 1);
  endtask

  // Runs to the next frame_start, counting samples where mode moved before it.
  task automatic wait_fs(input logic [1:0] hold_mode, output int early);
    int n;
    n = 0;
    early = 0;
    while (vid.frame_start !== 1'b1 && n < LIMIT) begin
      tick();
      n++;
      if (vid.frame_start !== 1'b1 && vid.mode !== hold_mode) early++;
    end
    check("fs_reached", vid.frame_start, 1);
  endtask

  task automatic press(input int idx);
    keys[idx] = 1'b1;
    repeat (4) tick();
    keys[idx] = 1'b0;
    repeat (4) tick();
  endtask

  initial begin
    int n, h, v, hd, vd, early, t_pix, t_fs1;
    int pix_viol, step_viol, hs_viol, vs_viol, de_viol, rgb_viol, max_h, max_v;
    int d_hs_viol, d_vs_viol, d_de_viol, d_first_low, d_last_low;
    logic [9:0] ph;
    logic ppix, de;

    keys  = 4'd0;
    reset = 1'b1;
    repeat (3) tick();
    check("rst_pix_en", vid.pix_en, 0);
    check("rst_hpos", vid.hpos, 0);
    check("rst_vpos", vid.vpos, 0);
    check("rst_hsync", vid.hsync, 1);
    check("rst_vsync", vid.vsync, 1);
    check("rst_display_on", vid.display_on, 1);
    check("rst_frame_start", vid.frame_start, 0);
    check("rst_mode", vid.mode, 0);
    check("rst_rgb", vid.rgb, 0);
`ifdef HVSYNC_FRAME_CNT_EN
    check("rst_frame_cnt", fc, 0);
`endif

    @(negedge clk);
    reset = 1'b0;
    tick();
    t_pix = cyc_ctr;
    check("exit_pix_en1", vid.pix_en, 1);
    check("exit_hpos0", vid.hpos, 0);
    check("exit_no_fs", vid.frame_start, 0);
    tick();
    check("exit_pix_en0", vid.pix_en, 0);
    check("exit_hpos_hold", vid.hpos, 0);
    tick();
    check("exit_pix_en2", vid.pix_en, 1);
    check("exit_hpos1", vid.hpos, 1);

    // Free run of the first frame, checking the timing maps every clk.
    pix_viol = 0; step_viol = 0; hs_viol = 0; vs_viol = 0; de_viol = 0; rgb_viol = 0;
    max_h = 0; max_v = 0;
    d_hs_viol = 0; d_vs_viol = 0; d_de_viol = 0; d_first_low = -1; d_last_low = -1;
    ph = vid.hpos;
    ppix = vid.pix_en;
    n = 0;
    while (vid.frame_start !== 1'b1 && n < LIMIT) begin
      tick();
      n++;
      h = int'(vid.hpos);
      v = int'(vid.vpos);
      if (vid.pix_en === ppix) pix_viol++;
      if (vid.hpos !== ph) begin
        if (vid.pix_en !== 1'b1 || h != ((int'(ph) == HT - 1) ? 0 : int'(ph) + 1)) step_viol++;
      end
      if (vid.hsync !== !(h >= HD + HF && h < HD + HF + HS)) hs_viol++;
      if (vid.vsync !== !(v >= VD + VB && v < VD + VB + VS)) vs_viol++;
      de = (h < HD) && (v < VD);
      if (vid.display_on !== de) de_viol++;
      if (vid.rgb !== (de ? vid.hpos[8:6] : 3'd0)) rgb_viol++;
      if (h > max_h) max_h = h;
      if (v > max_v) max_v = v;
      hd = int'(vid_d.hpos);
      vd = int'(vid_d.vpos);
      if (vid_d.hsync !== !(hd >= 656 && hd <= 751)) d_hs_viol++;
      if (vid_d.vsync !== !(vd >= 490 && vd <= 491)) d_vs_viol++;
      if (vid_d.display_on !== (hd < 640 && vd < 480)) d_de_viol++;
      if (vid_d.hsync === 1'b0) begin
        if (d_first_low < 0) d_first_low = hd;
        if (hd > d_last_low) d_last_low = hd;
      end
      ph = vid.hpos;
      ppix = vid.pix_en;
    end
    t_fs1 = cyc_ctr;
    check("first_fs_clk", cyc_ctr - t_pix, FRAME_CLK);
    check("fs_at_origin", {vid.vpos, vid.hpos}, 0);
    check("pix_en_toggle", pix_viol, 0);
    check("hpos_step", step_viol, 0);
    check("hsync_map", hs_viol, 0);
    check("vsync_map", vs_viol, 0);
    check("display_on_map", de_viol, 0);
    check("rgb_bars_map", rgb_viol, 0);
    check("hpos_max", max_h, HT - 1);
    check("vpos_max", max_v, VT - 1);
    check("d_hsync_map", d_hs_viol, 0);
    check("d_vsync_map", d_vs_viol, 0);
    check("d_display_on_map", d_de_viol, 0);
    check("d_hsync_first", d_first_low, 656);
    check("d_hsync_last", d_last_low, 751);
    tick();
    check("fs_one_clk", vid.frame_start, 0);
    tick();
`ifdef HVSYNC_FRAME_CNT_EN
    check("frame_cnt_one", fc, 1);
`endif

    // Three next presses in one frame give one step, applied only at frame_start.
    wait_pos(10, 5);
    press(0);
    press(0);
    press(0);
    wait_fs(2'd0, early);
    check("frame_period", cyc_ctr - t_fs1, FRAME_CLK);
    check("next_not_early", early, 0);
    tick();
    tick();
    check("mode_next", vid.mode, 1);

    // Checker pattern, then two prev presses back to mode 0.
    wait_pos(40, 10);
    check("checker_on", vid.rgb, 7);
    wait_pos(80, 10);
    check("checker_blank", vid.rgb, 0);
    press(1);
    press(1);
    wait_pos(40, 33);
    check("checker_off", vid.rgb, 0);
    wait_fs(2'd1, early);
    check("prev_not_early", early, 0);
    tick();
    tick();
    check("mode_prev", vid.mode, 0);

    // Simultaneous edges cancel.
    wait_pos(70, 5);
    check("bars_one", vid.rgb, 1);
    keys[1:0] = 2'b11;
    repeat (4) tick();
    keys[1:0] = 2'b00;
    repeat (4) tick();
    wait_fs(2'd0, early);
    check("cancel_not_early", early, 0);
    tick();
    tick();
    check("mode_cancel", vid.mode, 0);

    // prev from mode 0 wraps to 3; solid colour comes from keys[3:2].
    keys[3:2] = 2'b10;
    wait_pos(10, 5);
    press(1);
    wait_fs(2'd0, early);
    check("wrap_not_early", early, 0);
    tick();
    tick();
    check("mode_wrap", vid.mode, 3);
    wait_pos(20, 5);
    check("solid_rgb", vid.rgb, 2);
    wait_pos(80, 5);
    check("solid_blank", vid.rgb, 0);

    // An edge landing in the frame_start cycle waits for the following frame.
    wait_pos(HT - 1, VT - 1);
    keys[1] = 1'b1;
    tick();
    tick();
    check("edge_in_fs_cycle", vid.frame_start, 1);
    tick();
    tick();
    check("edge_in_fs_deferred", vid.mode, 3);
    keys[1] = 1'b0;
    wait_fs(2'd3, early);
    check("deferred_not_early", early, 0);
    tick();
    tick();
    check("mode_deferred", vid.mode, 2);

    wait_pos(32, 10);
    check("grid_col", vid.rgb, 7);
    wait_pos(33, 10);
    check("grid_gap", vid.rgb, 0);
    wait_pos(33, 32);
    check("grid_row", vid.rgb, 7);

    // Reset in the middle of both sync pulses with a request pending.
    press(0);
    wait_pos(HD + HF + 4, VD + VB);
    check("pre_rst_hsync", vid.hsync, 0);
    check("pre_rst_vsync", vid.vsync, 0);
    #2;
    reset = 1'b1;
    #1;
    check("async_rst_hpos", vid.hpos, 0);
    check("async_rst_vpos", vid.vpos, 0);
    check("async_rst_hsync", vid.hsync, 1);
    check("async_rst_vsync", vid.vsync, 1);
    check("async_rst_mode", vid.mode, 0);
    check("async_rst_pix_en", vid.pix_en, 0);
    check("async_rst_display_on", vid.display_on, 1);
    repeat (3) tick();
    check("rst_hold_hpos", vid.hpos, 0);
`ifdef HVSYNC_FRAME_CNT_EN
    check("rst_frame_cnt_clr", fc, 0);
`endif
    @(negedge clk);
    reset = 1'b0;
    tick();
    t_pix = cyc_ctr;
    wait_fs(2'd0, early);
    check("post_rst_fs_clk", cyc_ctr - t_pix, FRAME_CLK);
    tick();
    tick();
    check("pending_discarded", vid.mode, 0);
`ifdef HVSYNC_FRAME_CNT_EN
    check("frame_cnt_after_rst", fc, 1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
